// File: rtl/prince_sbox_layer_seq.sv
// rtl/prince_sbox_layer_seq.sv - byte-serial sequencer for the masked PRINCE inverse S-box layer
// Optional macro SBOX_IDLE_ZERO_EN: sb_in* driven to zero on every cycle without an issue.
module prince_sbox_layer_seq #(
    parameter int SBOX_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [63:0]  in_s1,
    input  logic [63:0]  in_s2,
    input  logic [63:0]  in_s3,
    output logic         busy,
    output logic         done,
    output logic [63:0]  out_s1,
    output logic [63:0]  out_s2,
    output logic [63:0]  out_s3,
    input  logic [215:0] rnd,
    input  logic         rnd_valid,
    output logic         rnd_ready,
    output logic [7:0]   sb_in1,
    output logic [7:0]   sb_in2,
    output logic [7:0]   sb_in3,
    output logic [215:0] sb_r,
    input  logic [7:0]   sb_out1,
    input  logic [7:0]   sb_out2,
    input  logic [7:0]   sb_out3
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  ic_q, ic_d;
    logic [3:0]  cc_q, cc_d;
    logic [63:0] sh1_q, sh1_d;
    logic [63:0] sh2_q, sh2_d;
    logic [63:0] sh3_q, sh3_d;
    logic [63:0] o1_q, o1_d;
    logic [63:0] o2_q, o2_d;
    logic [63:0] o3_q, o3_d;
    logic [SBOX_LAT-1:0] vld_q, vld_d;
    logic [2:0]  idx_q [SBOX_LAT];
    logic [2:0]  idx_d [SBOX_LAT];

    logic        issue;
    logic        capture;
    logic [2:0]  tail_idx;
    logic [7:0]  byte1, byte2, byte3;

    assign issue    = (state_q == ST_FEED) && rnd_valid;
    assign capture  = vld_q[SBOX_LAT-1] && ((state_q == ST_FEED) || (state_q == ST_DRAIN));
    assign tail_idx = idx_q[SBOX_LAT-1];

    // ic saturates at 7 on the last issue, so the selector rests on byte 7 after FEED
    assign byte1 = sh1_q[{ic_q, 3'b000} +: 8];
    assign byte2 = sh2_q[{ic_q, 3'b000} +: 8];
    assign byte3 = sh3_q[{ic_q, 3'b000} +: 8];

`ifdef SBOX_IDLE_ZERO_EN
    assign sb_in1 = issue ? byte1 : 8'h00;
    assign sb_in2 = issue ? byte2 : 8'h00;
    assign sb_in3 = issue ? byte3 : 8'h00;
`else
    assign sb_in1 = byte1;
    assign sb_in2 = byte2;
    assign sb_in3 = byte3;
`endif

    assign sb_r      = rnd;
    assign rnd_ready = (state_q == ST_FEED);
    assign busy      = (state_q == ST_FEED) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign out_s1    = o1_q;
    assign out_s2    = o2_q;
    assign out_s3    = o3_q;

    always_comb begin
        vld_d[0] = issue;
        idx_d[0] = ic_q;
        for (int i = 1; i < SBOX_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
        end
    end

    always_comb begin
        state_d = state_q;
        ic_d    = ic_q;
        cc_d    = cc_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        sh3_d   = sh3_q;
        o1_d    = o1_q;
        o2_d    = o2_q;
        o3_d    = o3_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sh1_d   = in_s1;
                    sh2_d   = in_s2;
                    sh3_d   = in_s3;
                    ic_d    = 3'd0;
                    cc_d    = 4'd0;
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                if (issue) begin
                    if (ic_q == 3'd7) begin
                        state_d = ST_DRAIN;
                    end else begin
                        ic_d = ic_q + 3'd1;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_DRAIN;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Returning results land in their own byte lane; shares stay separate
        if (capture) begin
            o1_d[{tail_idx, 3'b000} +: 8] = sb_out1;
            o2_d[{tail_idx, 3'b000} +: 8] = sb_out2;
            o3_d[{tail_idx, 3'b000} +: 8] = sb_out3;
            cc_d = cc_q + 4'd1;
            if (cc_q == 4'd7) begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ic_q    <= 3'd0;
            cc_q    <= 4'd0;
            sh1_q   <= 64'd0;
            sh2_q   <= 64'd0;
            sh3_q   <= 64'd0;
            o1_q    <= 64'd0;
            o2_q    <= 64'd0;
            o3_q    <= 64'd0;
            vld_q   <= '0;
            for (int i = 0; i < SBOX_LAT; i++) begin
                idx_q[i] <= 3'd0;
            end
        end else begin
            state_q <= state_d;
            ic_q    <= ic_d;
            cc_q    <= cc_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            sh3_q   <= sh3_d;
            o1_q    <= o1_d;
            o2_q    <= o2_d;
            o3_q    <= o3_d;
            vld_q   <= vld_d;
            for (int i = 0; i < SBOX_LAT; i++) begin
                idx_q[i] <= idx_d[i];
            end
        end
    end

endmodule
